pspin_her_sched: RTL

PSPIN_HER_SCHED -- requirements
Module: pspin_her_sched

---
 rtl/pspin_her_sched_pkg.sv | 18 +
 rtl/pspin_her_sched_rr_arbiter.sv | 52 +++++
 rtl/pspin_her_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pspin_her_sched_pkg.sv
// Shared definitions for the PsPIN HER scheduler: FSM state type and context-index sizing.
package pspin_her_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } her_state_e;

    localparam int unsigned DEFAULT_NUM_HANDLER_CTX = 4;

    // Index width for n contexts; never narrower than one bit so a single-context build still has a port.
    function automatic int unsigned ctx_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CTX_IDX_WIDTH = ctx_idx_width(DEFAULT_NUM_HANDLER_CTX);

endpackage

// File: rtl/pspin_her_sched_rr_arbiter.sv
// Round-robin arbiter: search starts at the context after the last grant; pointer moves only when en is set.
module pspin_rr_arbiter
    import pspin_her_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_HANDLER_CTX,
    parameter int unsigned IDX_W   = ctx_idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req[idx]) begin
                gnt_any     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && gnt_any) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pspin_her_sched.sv
// HER scheduler: credit-limited round-robin selection of handler contexts into a single output register.
// Optional per-context dispatch counters are enabled by defining PSPIN_HER_SCHED_STATS_EN.
module pspin_her_sched
    import pspin_her_sched_pkg::*;
#(
    parameter int unsigned NUM_HANDLER_CTX = 4,
    parameter int unsigned MSG_ID_WIDTH    = 10,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned CREDIT_WIDTH    = 8,
    localparam int unsigned IDX_W          = ctx_idx_width(NUM_HANDLER_CTX)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_HANDLER_CTX-1:0]                s_her_valid,
    output logic [NUM_HANDLER_CTX-1:0]                s_her_ready,
    input  logic [NUM_HANDLER_CTX*MSG_ID_WIDTH-1:0]   s_her_msgid,
    input  logic [NUM_HANDLER_CTX-1:0]                s_her_is_eom,
    input  logic [NUM_HANDLER_CTX*AXI_ADDR_WIDTH-1:0] s_her_addr,
    input  logic [NUM_HANDLER_CTX*AXI_ADDR_WIDTH-1:0] s_her_size,
    output logic                                      m_her_valid,
    input  logic                                      m_her_ready,
    output logic [IDX_W-1:0]                          m_her_ctx,
    output logic [MSG_ID_WIDTH-1:0]                   m_her_msgid,
    output logic                                      m_her_is_eom,
    output logic [AXI_ADDR_WIDTH-1:0]                 m_her_addr,
    output logic [AXI_ADDR_WIDTH-1:0]                 m_her_size,
    input  logic                                      fb_valid,
    input  logic [IDX_W-1:0]                          fb_ctx,
    output logic                                      fb_ready,
    input  logic [NUM_HANDLER_CTX*CREDIT_WIDTH-1:0]   conf_credits,
    input  logic                                      conf_valid,
    output logic [NUM_HANDLER_CTX*CREDIT_WIDTH-1:0]   ctx_inflight,
`ifdef PSPIN_HER_SCHED_STATS_EN
    output logic                                      fb_underflow,
    output logic [NUM_HANDLER_CTX*32-1:0]             stat_dispatched
`else
    output logic                                      fb_underflow
`endif
);

    her_state_e state_q, state_d;

    logic [NUM_HANDLER_CTX-1:0][CREDIT_WIDTH-1:0] inflight_q, inflight_d;
    logic [NUM_HANDLER_CTX-1:0][CREDIT_WIDTH-1:0] limit_q, limit_d;

    logic [IDX_W-1:0]          ctx_q, ctx_d;
    logic [MSG_ID_WIDTH-1:0]   msgid_q, msgid_d;
    logic                      eom_q, eom_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ADDR_WIDTH-1:0] size_q, size_d;
    logic                      uf_q, uf_d;

    logic [NUM_HANDLER_CTX-1:0] eligible;
    logic [NUM_HANDLER_CTX-1:0] gnt_oh;
    logic [IDX_W-1:0]           gnt_idx;
    logic                       gnt_any;
    logic                       grant_en;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_HANDLER_CTX; i++) begin
            eligible[i] = s_her_valid[i] && (inflight_q[i] < limit_q[i]);
        end
    end

    // Output register can take a new HER when empty or when its current one leaves this cycle.
    assign grant_en = !rst && gnt_any && ((state_q == ST_EMPTY) || m_her_ready);

    pspin_rr_arbiter #(
        .NUM_REQ (NUM_HANDLER_CTX),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .en      (grant_en),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign s_her_ready = grant_en ? gnt_oh : '0;

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        msgid_d = msgid_q;
        eom_d   = eom_q;
        addr_d  = addr_q;
        size_d  = size_q;
        if (grant_en) begin
            state_d = ST_FULL;
            ctx_d   = gnt_idx;
            for (int unsigned i = 0; i < NUM_HANDLER_CTX; i++) begin
                if (gnt_oh[i]) begin
                    msgid_d = s_her_msgid[i*MSG_ID_WIDTH +: MSG_ID_WIDTH];
                    eom_d   = s_her_is_eom[i];
                    addr_d  = s_her_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    size_d  = s_her_size[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                end
            end
        end else if ((state_q == ST_FULL) && m_her_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Feedback to a zero count is dropped and latched as underflow; grant+feedback on one context cancel.
    always_comb begin
        logic inc, dec, fb_hit;
        inflight_d = inflight_q;
        fb_hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_HANDLER_CTX; i++) begin
            inc    = grant_en && gnt_oh[i];
            dec    = fb_valid && (fb_ctx == IDX_W'(i)) && (inflight_q[i] != '0);
            fb_hit = fb_hit | dec;
            if (inc && !dec && (inflight_q[i] != '1)) begin
                inflight_d[i] = inflight_q[i] + CREDIT_WIDTH'(1);
            end else if (dec && !inc) begin
                inflight_d[i] = inflight_q[i] - CREDIT_WIDTH'(1);
            end
        end
        uf_d    = uf_q | (fb_valid && !fb_hit);
        limit_d = conf_valid ? conf_credits : limit_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ctx_q      <= '0;
            msgid_q    <= '0;
            eom_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            inflight_q <= '0;
            limit_q    <= '0;
            uf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            msgid_q    <= msgid_d;
            eom_q      <= eom_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            inflight_q <= inflight_d;
            limit_q    <= limit_d;
            uf_q       <= uf_d;
        end
    end

    assign m_her_valid  = (state_q == ST_FULL);
    assign m_her_ctx    = ctx_q;
    assign m_her_msgid  = msgid_q;
    assign m_her_is_eom = eom_q;
    assign m_her_addr   = addr_q;
    assign m_her_size   = size_q;
    assign fb_ready     = 1'b1;
    assign ctx_inflight = inflight_q;
    assign fb_underflow = uf_q;

`ifdef PSPIN_HER_SCHED_STATS_EN
    logic [NUM_HANDLER_CTX-1:0][31:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int unsigned i = 0; i < NUM_HANDLER_CTX; i++) begin
            if (m_her_valid && m_her_ready && (ctx_q == IDX_W'(i))) begin
                stat_d[i] = stat_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_dispatched = stat_q;
`else
`endif

endmodule
